// File: rtl/inst_trace_buffer.sv
// Instruction trace buffer: samples fetched pc/inst pairs into a FIFO of
// sequence-tagged records and drains them over a valid/ready stream.
module inst_trace_buffer #(
    parameter int          DEPTH    = 16,
    parameter int          ADDR_W   = 4,
    parameter logic [31:0] PC_RESET = 32'h00400000
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cap_en,
    input  logic              clear,
    input  logic [31:0]       pc,
    input  logic [31:0]       inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_seq,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] inst;
    } rec_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    rec_t              mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_nxt;
    logic [ADDR_W:0]   remain;
    logic [31:0]       last_pc;
    logic              have_last;
    logic [15:0]       seq;
    logic              full;
    logic              sample;
    logic              pop;
    logic              push;
    logic              drop;

    assign full   = (count == FULL_CNT);
    assign sample = cap_en & (~have_last | (pc != last_pc));
    assign pop    = out_valid & out_ready;
    assign push   = sample & (~full | pop);
    assign drop   = sample & full & ~pop;
    assign rd_nxt = rd_ptr + ADDR_W'(pop);
    // Records stored before this edge that survive the pop; a record
    // written this edge only becomes visible one edge later.
    assign remain = count - (ADDR_W+1)'(pop);

    always_ff @(posedge clk_in) begin
        if (push && !clear) begin
            mem[wr_ptr] <= '{seq: seq, pc: pc, inst: inst};
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            seq       <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            have_last <= 1'b0;
            last_pc   <= PC_RESET;
            out_valid <= 1'b0;
            out_seq   <= '0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            seq       <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            have_last <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (sample) begin
                last_pc   <= pc;
                have_last <= 1'b1;
                seq       <= seq + 16'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            rd_ptr <= rd_nxt;
            if (push && !pop) begin
                count <= count + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (ADDR_W+1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
            out_valid <= (remain != '0);
            if (remain != '0) begin
                out_seq  <= mem[rd_nxt].seq;
                out_pc   <= mem[rd_nxt].pc;
                out_inst <= mem[rd_nxt].inst;
            end
        end
    end

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Bench for inst_trace_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_inst_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [15:0] s;
        logic [31:0] p;
        logic [31:0] i;
    } rec_t;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        cap_en = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_seq;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int nerr = 0;
    int nchk = 0;

    inst_trace_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk_in(clk_in), .reset(reset), .cap_en(cap_en), .clear(clear),
        .pc(pc), .inst(inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_seq(out_seq), .out_pc(out_pc), .out_inst(out_inst),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: q holds stored records, head visible one edge later.
    rec_t        q[$];
    int          m_popped[$];
    logic [15:0] m_seq = '0;
    logic [31:0] m_last = '0;
    logic        m_have = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_drop = '0;
    logic        m_valid = 1'b0;
    rec_t        m_head = '0;

    always @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_seq = '0; m_have = 1'b0; m_ovf = 1'b0; m_drop = '0;
            m_valid = 1'b0; m_head = '0;
        end else if (clear) begin
            q.delete();
            m_seq = '0; m_have = 1'b0; m_ovf = 1'b0; m_drop = '0;
            m_valid = 1'b0;
        end else begin
            int vis;
            if (m_valid && out_ready) begin
                m_popped.push_back(int'(q[0].s));
                void'(q.pop_front());
            end
            vis = q.size();
            if (cap_en && (!m_have || pc != m_last)) begin
                if (q.size() < DEPTH) begin
                    q.push_back('{s: m_seq, p: pc, i: inst});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
                m_last = pc;
                m_have = 1'b1;
                m_seq = m_seq + 16'd1;
            end
            m_valid = (vis != 0);
            if (vis != 0) m_head = q[0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        chk("valid", 32'(out_valid), 32'(m_valid));
        chk("count", 32'(count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (m_valid) begin
            chk("out_seq", 32'(out_seq), 32'(m_head.s));
            chk("out_pc", out_pc, m_head.p);
            chk("out_inst", out_inst, m_head.i);
        end
    end

    task automatic step(input logic c, input logic [31:0] p,
                        input logic [31:0] i);
        cap_en = c;
        pc = p;
        inst = i;
        @(posedge clk_in);
        @(negedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, pc, inst);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        idle(2);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_seq", 32'(out_seq), 32'd0);
        @(negedge clk_in);
        reset = 1'b1;
        #1;

        // Basic capture and latency
        out_ready = 1'b1;
        step(1'b1, 32'h00400000, 32'h3C011001);
        chk("lat_valid0", 32'(out_valid), 32'd0);
        chk("lat_count1", 32'(count), 32'd1);
        step(1'b1, 32'h00400004, 32'h34210000);
        chk("lat_valid1", 32'(out_valid), 32'd1);
        chk("first_seq", 32'(out_seq), 32'd0);
        chk("first_pc", out_pc, 32'h00400000);
        chk("first_inst", out_inst, 32'h3C011001);
        step(1'b1, 32'h00400008, 32'h8C220000);
        chk("second_seq", 32'(out_seq), 32'd1);
        idle(4);
        chk("drain_count", 32'(count), 32'd0);
        chk("popped3", 32'(m_popped.size()), 32'd3);
        chk("popped3_last", 32'(m_popped[2]), 32'd2);

        // Self-loop suppression
        for (int k = 0; k < 10; k++) step(1'b1, 32'h0040001C, 32'h08100007);
        idle(3);
        chk("loop_once", 32'(m_popped.size()), 32'd4);
        chk("loop_seq", 32'(m_popped[3]), 32'd3);
        step(1'b1, 32'h00400020, 32'h00000000);
        step(1'b0, pc, inst);
        chk("after_loop_valid", 32'(out_valid), 32'd1);
        chk("after_loop_seq", 32'(out_seq), 32'd4);
        idle(2);

        // Overflow, then full with simultaneous push and pop
        clear = 1'b1;
        step(1'b0, pc, inst);
        clear = 1'b0;
        out_ready = 1'b0;
        m_popped.delete();
        for (int k = 0; k < 20; k++)
            step(1'b1, 32'h00500000 + 32'(4 * k), 32'(k));
        chk("full_count", 32'(count), 32'd16);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_drop", 32'(drop_cnt), 32'd4);
        chk("full_head", 32'(out_seq), 32'd0);
        out_ready = 1'b1;
        step(1'b1, 32'h00600000, 32'h000000AA);
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_drop", 32'(drop_cnt), 32'd4);
        idle(16);
        chk("drain_all", 32'(count), 32'd0);
        chk("drain_n", 32'(m_popped.size()), 32'd17);
        chk("drain_15", 32'(m_popped[15]), 32'd15);
        chk("drain_20", 32'(m_popped[16]), 32'd20);

        // Clear with coincident sample
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++)
            step(1'b1, 32'h00700000 + 32'(4 * k), 32'(k));
        chk("pre_clr_count", 32'(count), 32'd7);
        chk("pre_clr_ovf", 32'(overflow), 32'd1);
        clear = 1'b1;
        step(1'b1, 32'h00800000, 32'h11111111);
        clear = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        out_ready = 1'b1;
        step(1'b1, 32'h00800000, 32'h22222222);
        step(1'b0, pc, inst);
        chk("clr_next_valid", 32'(out_valid), 32'd1);
        chk("clr_next_seq", 32'(out_seq), 32'd0);
        chk("clr_next_inst", out_inst, 32'h22222222);

        // Reset in the middle of a drain
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h00900000 + 32'(4 * k), 32'(k));
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_count", 32'(count), 32'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_seq", 32'(out_seq), 32'd0);
        chk("arst_inst", out_inst, 32'd0);
        @(negedge clk_in);
        reset = 1'b1;
        #1;
        out_ready = 1'b1;
        step(1'b1, 32'h00400000, 32'h3C011001);
        step(1'b0, pc, inst);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_seq", 32'(out_seq), 32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
